exmem_skid_stage: RTL and testbench
===================================

// Module: exmem_skid_stage
// PURPOSE
//  Parametrised EX->MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//  Carries branch target, ALU result, store data, destination register and a control bundle.
//  The skid buffer keeps in_ready registered, so MEM back-pressure does not form a
//  combinational path into EX. Empty slots present all-zero payload, so a bubble is a
//  true NOP downstream. Flush squashes every held entry.
// PARAMETERS
//  XLEN    32  width of pc_branch, alu and wdata fields
//  RD_W    5   destination register index width
//  CTRL_W  8   control bundle width {branch,memread,memtoreg,memwrite,regwrite,taken,br_taken,zero}
//  CNT_W   16  width of the stall-cycle counter
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  flush          in   1       squash all held entries (branch mispredict)
//  in_valid       in   1       EX presents a valid entry
//  in_ready       out  1       stage can accept; registered
//  in_pc_branch   in   XLEN    branch target
//  in_alu         in   XLEN    ALU result
//  in_wdata       in   XLEN    store data
//  in_rd          in   RD_W    destination register
//  in_ctrl        in   CTRL_W  control bundle
//  out_valid      out  1       MEM-side entry valid
//  out_ready      in   1       MEM consumes the entry this cycle
//  out_pc_branch  out  XLEN    \
//  out_alu        out  XLEN     |  registered head-entry fields;
//  out_wdata      out  XLEN     |  all zero when out_valid=0
//  out_rd         out  RD_W     |
//  out_ctrl       out  CTRL_W  /
//  occupancy      out  2       entries held: 0, 1 or 2
//  stall_cycles   out  CNT_W   saturating count of cycles with out_valid & !out_ready
// BEHAVIOUR
//  - Reset: state EMPTY, main and skid registers 0, in_ready=1, out_valid=0,
//    occupancy=0, stall_cycles=0, all out_* = 0.
//  - Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Latency: one cycle. An entry accepted at edge N appears on out_* after edge N
//    if the stage was EMPTY, or ONE with out_fire.
//  - State EMPTY (occ 0):
//      in_fire -> ONE, main <= in.
//  - State ONE (occ 1):
//      in_fire & out_fire  -> ONE,   main <= in
//      in_fire & !out_fire -> FULL,  skid <= in
//      !in_fire & out_fire -> EMPTY, main <= 0
//      neither             -> hold
//  - State FULL (occ 2): in_ready=0.
//      out_fire -> ONE, main <= skid, skid <= 0; else hold.
//  - in_ready = (state != FULL), driven from a flop; out_valid = (state != EMPTY).
//  - Order is strict FIFO. Payload bits are never modified in flight.
//  - Flush:
//      * Next state EMPTY; main and skid cleared to 0.
//      * An input offered in the same cycle is dropped.
//      * An output consumed in the same cycle counts as delivered.
//      * Flush has priority over every transition.
//  - rst has priority over flush; both act at the clock edge only.
//  - stall_cycles:
//      * Increments on each cycle with out_valid & !out_ready.
//      * Saturates at 2^CNT_W-1.
//      * Cleared by rst only; flush does not clear it.
//  - in_valid while in_ready=0 is ignored. The upstream holds its data; there is no error.
// TESTING
//  1 Reset then idle: in_valid=0 for 5 cycles -> out_valid=0, all out_*=0, in_ready=1, occupancy=0.
//  2 Streaming with out_ready=1: alu=1,2,3,4 on consecutive cycles
//    -> out_alu=1,2,3,4 one cycle later each, occupancy stays 1.
//  3 Back-pressure: out_ready=0, push alu=A then B
//    -> occupancy=2, in_ready=0, out_alu=A.
//    Then out_ready=1 -> A, then B delivered; in_ready=1 after the first pop.
//  4 Flush while FULL with in_valid=1 (alu=C)
//    -> next cycle occupancy=0, out_ctrl=0, out_alu=0; C never appears.
//  5 Stall counter with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles
//    -> stall_cycles=15 (saturated); a flush leaves it at 15; rst -> 0.
//  6 Simultaneous in_fire & out_fire in state ONE over 100 random cycles
//    -> output order matches a reference queue and occupancy never exceeds 2.

Source files
------------

// File: rtl/exmem_skid_stage.sv
// rtl/exmem_skid_stage.sv - EX->MEM pipeline stage with 2-entry skid buffer and registered in_ready
module exmem_skid_stage #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc_branch,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc_branch,
  output logic [XLEN-1:0]   out_alu,
  output logic [XLEN-1:0]   out_wdata,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int PW = 3*XLEN + RD_W + CTRL_W;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t        state, state_n;
  logic [PW-1:0] main_q, main_n, skid_q, skid_n, in_bus;
  logic          in_fire, out_fire;

  assign in_bus   = {in_pc_branch, in_alu, in_wdata, in_rd, in_ctrl};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Main register is the head entry; emptied slots are zeroed so bubbles are NOPs.
  assign {out_pc_branch, out_alu, out_wdata, out_rd, out_ctrl} = main_q;

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = EMPTY;
      main_n  = '0;
      skid_n  = '0;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          state_n = ONE;
          main_n  = in_bus;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_n = in_bus;
          end else if (in_fire) begin
            state_n = FULL;
            skid_n  = in_bus;
          end else if (out_fire) begin
            state_n = EMPTY;
            main_n  = '0;
          end
        end
        FULL: if (out_fire) begin
          state_n = ONE;
          main_n  = skid_q;
          skid_n  = '0;
        end
        default: begin
          state_n = EMPTY;
          main_n  = '0;
          skid_n  = '0;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the next state so they leave flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state     <= state_n;
      main_q    <= main_n;
      skid_q    <= skid_n;
      in_ready  <= (state_n != FULL);
      out_valid <= (state_n != EMPTY);
      occupancy <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_exmem_skid_stage.sv
// tb/tb_exmem_skid_stage.sv - directed and random checks of exmem_skid_stage against a queue model
module tb_exmem_skid_stage;

  localparam int XLEN   = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int SAT    = 15;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   wdata;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]   in_pc_branch, in_alu, in_wdata, out_pc_branch, out_alu, out_wdata;
  logic [RD_W-1:0]   in_rd, out_rd;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cycles;

  int     checks = 0;
  int     errors = 0;
  entry_t mq[$];
  int     mcnt = 0;

  exmem_skid_stage #(.XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_branch(in_pc_branch), .in_alu(in_alu), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_branch(out_pc_branch), .out_alu(out_alu), .out_wdata(out_wdata),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t mk(input logic [XLEN-1:0] alu);
    entry_t e;
    e.pc    = alu + 32'h1000;
    e.alu   = alu;
    e.wdata = ~alu;
    e.rd    = alu[RD_W-1:0] ^ 5'h15;
    e.ctrl  = alu[CTRL_W-1:0] | 8'h01;
    return e;
  endfunction

  function automatic entry_t rnd();
    entry_t e;
    e = {$urandom, $urandom, $urandom, $urandom};
    return e;
  endfunction

  task automatic compare_all();
    entry_t exp_e;
    entry_t obs_e;
    exp_e = (mq.size() > 0) ? mq[0] : '0;
    obs_e = {out_pc_branch, out_alu, out_wdata, out_rd, out_ctrl};
    chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(mq.size() < 2));
    chk("occupancy", 128'(occupancy), 128'(mq.size()));
    chk("payload", 128'(obs_e), 128'(exp_e));
    chk("stall_cycles", 128'(stall_cycles), 128'(mcnt));
  endtask

  // Drive one cycle of inputs, advance the queue model across the edge, then compare.
  task automatic step(input logic r, input logic f, input logic iv, input logic orr, input entry_t e);
    bit in_f, out_f;
    rst = r; flush = f; in_valid = iv; out_ready = orr;
    {in_pc_branch, in_alu, in_wdata, in_rd, in_ctrl} = e;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mcnt = 0;
    end else begin
      in_f  = iv && (mq.size() < 2);
      out_f = orr && (mq.size() > 0);
      if ((mq.size() > 0) && !orr && (mcnt < SAT)) mcnt++;
      if (f) mq.delete();
      else begin
        if (out_f) void'(mq.pop_front());
        if (in_f) mq.push_back(e);
      end
    end
    #1 compare_all();
  endtask

  initial begin
    // 1: reset then idle
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, '0);
    chk("idle_occ", 128'(occupancy), 128'(0));

    // 2: streaming with out_ready=1
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, 1, mk(i));
      chk("stream_alu", 128'(out_alu), 128'(i));
      chk("stream_occ", 128'(occupancy), 128'(1));
    end
    step(0, 0, 0, 1, '0);

    // 3: back-pressure, then drain
    step(0, 0, 1, 0, mk(32'hA));
    step(0, 0, 1, 0, mk(32'hB));
    chk("bp_occ", 128'(occupancy), 128'(2));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_head", 128'(out_alu), 128'(32'hA));
    step(0, 0, 1, 0, mk(32'hD));
    step(0, 0, 0, 1, '0);
    chk("bp_pop1", 128'(out_alu), 128'(32'hB));
    chk("bp_ready_after_pop", 128'(in_ready), 128'(1));
    step(0, 0, 0, 1, '0);
    chk("bp_drained", 128'(out_valid), 128'(0));

    // 4: flush while FULL with a concurrent input
    step(0, 0, 1, 0, mk(32'h11));
    step(0, 0, 1, 0, mk(32'h22));
    step(0, 1, 1, 0, mk(32'hC));
    chk("flush_occ", 128'(occupancy), 128'(0));
    chk("flush_alu", 128'(out_alu), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, '0);

    // 5: stall counter saturation, survives flush, cleared by rst
    step(0, 0, 1, 0, mk(32'h55));
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, '0);
    chk("stall_sat", 128'(stall_cycles), 128'(SAT));
    step(0, 1, 0, 0, '0);
    chk("stall_after_flush", 128'(stall_cycles), 128'(SAT));
    step(1, 0, 0, 0, '0);
    chk("stall_after_rst", 128'(stall_cycles), 128'(0));

    // 6: random traffic against the queue model
    for (int i = 0; i < 100; i++) begin
      step(0, ($urandom_range(0, 19) == 0), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, rnd());
      chk("rand_occ_bound", 128'(occupancy <= 2'd2), 128'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
